glyph_row_fetch: RTL and testbench

//  Shared 7-segment-style digit font server for the RGB value display: up to NUM_CH

---
 rtl/glyph_pkg.sv | 72 +++++++
 rtl/glyph_row_fetch_if.sv | 28 ++
 rtl/glyph_rom.sv | 53 +++++
 rtl/glyph_row_fetch.sv | 130 +++++++++++++
 tb/tb_glyph_row_fetch.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/glyph_pkg.sv
// Glyph font definitions shared by the row fetch block and its ROM.
// Digits are drawn as thick seven-segment glyphs on a 16x16 grid.
package glyph_pkg;

   localparam int CODE_W      = 4;
   localparam int DEF_GLYPH_W = 16;
   localparam int DEF_GLYPH_H = 16;
   localparam int FONT_W      = 16;
   localparam int FONT_H      = 16;
   localparam int NUM_GLYPHS  = 12;

   localparam logic [3:0] GLYPH_BLANK = 4'd10;
   localparam logic [3:0] GLYPH_MINUS = 4'd11;

   // Segment set, bit order {a,b,c,d,e,f,g}
   typedef logic [6:0] seg_t;

   localparam logic [FONT_W-1:0] FONT_BAR   = 16'h1FF8;
   localparam logic [FONT_W-1:0] FONT_LEFT  = 16'hE000;
   localparam logic [FONT_W-1:0] FONT_RIGHT = 16'h0007;
   localparam logic [FONT_W-1:0] FONT_NONE  = 16'h0000;

   function automatic seg_t glyph_segs(input logic [3:0] code);
      seg_t seg;
      case (code)
         4'd0:        seg = 7'b1111110;
         4'd1:        seg = 7'b0110000;
         4'd2:        seg = 7'b1101101;
         4'd3:        seg = 7'b1111001;
         4'd4:        seg = 7'b0110011;
         4'd5:        seg = 7'b1011011;
         4'd6:        seg = 7'b1011111;
         4'd7:        seg = 7'b1110000;
         4'd8:        seg = 7'b1111111;
         4'd9:        seg = 7'b1111011;
         GLYPH_MINUS: seg = 7'b0000001;
         default:     seg = 7'b0000000;
      endcase
      return seg;
   endfunction

   // Bitmap of one font row. Rows 0-2 top bar, 3-6 upper sides, 7-8 middle,
   // 9-12 lower sides, 13-15 bottom bar. Without a middle bar the sides run
   // through rows 7-8 so that '0' is a closed outline.
   function automatic logic [FONT_W-1:0] font_row(input logic [3:0] code, input int row);
      seg_t seg;
      logic [FONT_W-1:0] r;
      seg = glyph_segs(code);
      if (row < 0) begin
         r = FONT_NONE;
      end else if (row <= 2) begin
         r = seg[6] ? FONT_BAR : FONT_NONE;
      end else if (row <= 6) begin
         r = (seg[1] ? FONT_LEFT : FONT_NONE) | (seg[5] ? FONT_RIGHT : FONT_NONE);
      end else if (row <= 8) begin
         if (seg[0]) begin
            r = FONT_BAR;
         end else begin
            r = ((seg[1] & seg[2]) ? FONT_LEFT : FONT_NONE) |
                ((seg[5] & seg[4]) ? FONT_RIGHT : FONT_NONE);
         end
      end else if (row <= 12) begin
         r = (seg[2] ? FONT_LEFT : FONT_NONE) | (seg[4] ? FONT_RIGHT : FONT_NONE);
      end else if (row <= 15) begin
         r = seg[3] ? FONT_BAR : FONT_NONE;
      end else begin
         r = FONT_NONE;
      end
      return r;
   endfunction

endpackage

// File: rtl/glyph_row_fetch_if.sv
// Request/response bundle between the display field requesters and the
// glyph row fetch server.
interface glyph_row_fetch_if #(
   parameter int NUM_CH  = 9,
   parameter int GLYPH_W = 16,
   parameter int GLYPH_H = 16,
   parameter int CODE_W  = 4
);
   localparam int RW = $clog2(GLYPH_H);

   logic [NUM_CH-1:0]         req_valid;
   logic [NUM_CH-1:0]         req_ready;
   logic [NUM_CH*CODE_W-1:0]  req_code;
   logic [NUM_CH*RW-1:0]      req_row;
   logic [NUM_CH-1:0]         req_inv;
   logic [NUM_CH-1:0]         rsp_valid;
   logic [NUM_CH*GLYPH_W-1:0] rsp_data;

   modport master (
      output req_valid, req_code, req_row, req_inv,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_code, req_row, req_inv,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/glyph_rom.sv
// Synchronous glyph ROM: one row bitmap per {code,row}, one cycle read latency.
// Out-of-range codes and rows read as blank.
module glyph_rom #(
   parameter int GLYPH_W = 16,
   parameter int GLYPH_H = 16,
   parameter int CODE_W  = 4,
   parameter int RW      = $clog2(GLYPH_H)
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [CODE_W-1:0]  code,
   input  logic [RW-1:0]      row,
   output logic [GLYPH_W-1:0] data
);
   import glyph_pkg::*;

   logic [FONT_W-1:0] font_s;

   // Map the 16-pixel font row onto GLYPH_W pixels, left-aligned.
   function automatic logic [GLYPH_W-1:0] fit_row(input logic [FONT_W-1:0] f);
      logic [GLYPH_W-1:0] r;
      r = '0;
      for (int b = 0; b < GLYPH_W; b++) begin
         int col;
         col = GLYPH_W - 1 - b;
         if (col < FONT_W) begin
            r[b] = f[FONT_W-1-col];
         end else begin
            r[b] = 1'b0;
         end
      end
      return r;
   endfunction

   // Font lookup with blanking of unknown codes and rows beyond the glyph.
   always_comb begin
      font_s = FONT_NONE;
      if ((int'(code) < NUM_GLYPHS) && (int'(row) < GLYPH_H)) begin
         font_s = font_row(4'(code), int'(row));
      end else begin
         font_s = FONT_NONE;
      end
   end

   // Registered read port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data <= '0;
      end else begin
         data <= fit_row(font_s);
      end
   end
endmodule

// File: rtl/glyph_row_fetch.sv
// Shared glyph row server: round-robin arbitration of NUM_CH requesters into a
// single glyph ROM, answers routed back to each requester's own output slice.
module glyph_row_fetch #(
   parameter int NUM_CH  = 9,
   parameter int GLYPH_W = glyph_pkg::DEF_GLYPH_W,
   parameter int GLYPH_H = glyph_pkg::DEF_GLYPH_H,
   parameter int CODE_W  = glyph_pkg::CODE_W
)(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   glyph_row_fetch_if.slave bus
);
   import glyph_pkg::*;

   localparam int RW   = $clog2(GLYPH_H);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [CH_W-1:0]           ptr_r;
   logic [CH_W-1:0]           grant_idx_s;
   logic                      grant_any_s;
   logic [NUM_CH-1:0]         grant_s;
   logic [CODE_W-1:0]         sel_code_s;
   logic [RW-1:0]             sel_row_s;
   logic                      sel_inv_s;
   logic [GLYPH_W-1:0]        rom_data_s;

   logic                      s1_valid_r;
   logic [CH_W-1:0]           s1_ch_r;
   logic                      s1_inv_r;
   logic [NUM_CH-1:0]         rsp_valid_r;
   logic [NUM_CH*GLYPH_W-1:0] rsp_data_r;

   // Round-robin search from ptr_r; nothing is granted in reset or during flush.
   always_comb begin
      int idx;
      idx         = 0;
      grant_any_s = 1'b0;
      grant_idx_s = '0;
      if (rst_n && !flush) begin
         for (int off = 0; off < NUM_CH; off++) begin
            idx = int'(ptr_r) + off;
            if (idx >= NUM_CH) begin
               idx = idx - NUM_CH;
            end else begin
               idx = idx;
            end
            if (!grant_any_s && bus.req_valid[idx]) begin
               grant_any_s = 1'b1;
               grant_idx_s = CH_W'(idx);
            end else begin
               grant_any_s = grant_any_s;
            end
         end
      end else begin
         grant_any_s = 1'b0;
      end
   end

   // One-hot grant vector and the granted request's fields.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         grant_s[i] = grant_any_s && (grant_idx_s == CH_W'(i));
      end
      sel_code_s = bus.req_code[int'(grant_idx_s)*CODE_W +: CODE_W];
      sel_row_s  = bus.req_row[int'(grant_idx_s)*RW +: RW];
      sel_inv_s  = bus.req_inv[grant_idx_s];
   end

   assign bus.req_ready = grant_s;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_data  = rsp_data_r;

   glyph_rom #(
      .GLYPH_W (GLYPH_W),
      .GLYPH_H (GLYPH_H),
      .CODE_W  (CODE_W),
      .RW      (RW)
   ) u_rom (
      .clk   (clk),
      .rst_n (rst_n),
      .code  (sel_code_s),
      .row   (sel_row_s),
      .data  (rom_data_s)
   );

   // Round-robin pointer: move past the channel just accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r <= '0;
      end else if (grant_any_s) begin
         if (grant_idx_s == CH_W'(NUM_CH - 1)) begin
            ptr_r <= '0;
         end else begin
            ptr_r <= grant_idx_s + CH_W'(1);
         end
      end else begin
         ptr_r <= ptr_r;
      end
   end

   // Stage 1: channel and inversion travel alongside the ROM read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_ch_r    <= '0;
         s1_inv_r   <= 1'b0;
      end else begin
         s1_valid_r <= grant_any_s & ~flush;
         s1_ch_r    <= grant_idx_s;
         s1_inv_r   <= sel_inv_s;
      end
   end

   // Stage 2: write the row into its channel slice and pulse that channel's valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_r <= '0;
         rsp_data_r  <= '0;
      end else begin
         rsp_valid_r <= '0;
         if (s1_valid_r && !flush) begin
            rsp_valid_r[s1_ch_r] <= 1'b1;
            rsp_data_r[int'(s1_ch_r)*GLYPH_W +: GLYPH_W] <= rom_data_s ^ {GLYPH_W{s1_inv_r}};
         end else begin
            rsp_data_r <= rsp_data_r;
         end
      end
   end
endmodule

// File: tb/tb_glyph_row_fetch.sv
// Directed bench for glyph_row_fetch: a round-robin reference predicts grants,
// expected rows are queued at accept time and compared when they fall due.
module tb_glyph_row_fetch;

   localparam int NCH = 9;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;

   glyph_row_fetch_if #(.NUM_CH(NCH), .GLYPH_W(16), .GLYPH_H(16), .CODE_W(4)) bus ();

   glyph_row_fetch #(.NUM_CH(NCH), .GLYPH_W(16), .GLYPH_H(16), .CODE_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          ch;
      logic [15:0] d;
      int          due;
   } exp_t;

   exp_t        q[$];
   logic [15:0] exp_data[NCH];
   int          ptr_m = 0;
   int          cyc   = 0;
   int          tests = 0;
   int          fails = 0;

   // Hand-written reference rows for the glyphs exercised here.
   function automatic logic [15:0] ref_row(input int code, input int row, input bit inv);
      logic [15:0] r;
      if (code >= 12 || row >= 16) r = 16'h0000;
      else if (code == 0)  r = (row <= 2 || row >= 13) ? 16'h1FF8 : 16'hE007;
      else if (code == 1)  r = (row >= 3 && row <= 12) ? 16'h0007 : 16'h0000;
      else if (code == 8 && row == 7) r = 16'h1FF8;
      else if (code == 10) r = 16'h0000;
      else if (code == 11) r = (row == 7 || row == 8) ? 16'h1FF8 : 16'h0000;
      else r = 16'hxxxx;
      return inv ? ~r : r;
   endfunction

   task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int ch, input bit v, input int code, input int row, input bit inv);
      bus.req_valid[ch]       = v;
      bus.req_code[ch*4 +: 4] = 4'(code);
      bus.req_row[ch*4 +: 4]  = 4'(row);
      bus.req_inv[ch]         = inv;
   endtask

   function automatic logic [143:0] pack_exp();
      logic [143:0] v;
      for (int i = 0; i < NCH; i++) v[i*16 +: 16] = exp_data[i];
      return v;
   endfunction

   // One clock: predict and check the grant, then check responses due this cycle.
   task automatic step(input bit drop);
      int g;
      logic [8:0] exp_rdy;
      logic [8:0] exp_v;
      g       = -1;
      exp_rdy = 9'd0;
      exp_v   = 9'd0;
      #1;
      if (!flush) begin
         for (int off = 0; off < NCH; off++) begin
            int idx;
            idx = (ptr_m + off) % NCH;
            if (g < 0 && bus.req_valid[idx]) g = idx;
         end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", {135'd0, bus.req_ready}, {135'd0, exp_rdy});
      if (g >= 0) begin
         q.push_back('{ch: g,
                       d: ref_row(int'(bus.req_code[g*4 +: 4]), int'(bus.req_row[g*4 +: 4]), bus.req_inv[g]),
                       due: cyc + 2});
         ptr_m = (g + 1) % NCH;
      end
      if (flush) begin
         while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      while (q.size() > 0 && q[0].due == cyc) begin
         exp_v[q[0].ch]     = 1'b1;
         exp_data[q[0].ch]  = q[0].d;
         void'(q.pop_front());
      end
      check("rsp_valid", {135'd0, bus.rsp_valid}, {135'd0, exp_v});
      check("rsp_data", bus.rsp_data, pack_exp());
      if (drop && g >= 0) bus.req_valid[g] = 1'b0;
   endtask

   task automatic single(input int ch, input int code, input int row, input bit inv);
      set_req(ch, 1'b1, code, row, inv);
      step(1'b1);
      step(1'b0);
   endtask

   initial begin
      for (int i = 0; i < NCH; i++) exp_data[i] = 16'h0000;
      bus.req_valid = '1;
      bus.req_code  = '0;
      bus.req_row   = '0;
      bus.req_inv   = '0;

      // 1: reset with every requester asking
      #12;
      check("reset_ready", {135'd0, bus.req_ready}, 144'd0);
      check("reset_rsp_valid", {135'd0, bus.rsp_valid}, 144'd0);
      check("reset_rsp_data", bus.rsp_data, 144'd0);
      bus.req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // 2: single requests on channel 0
      single(0, 0, 0, 1'b0);
      single(0, 0, 3, 1'b0);
      single(0, 0, 3, 1'b1);

      // 3: fairness, all channels valid; ch8 first moves the pointer to 0
      single(8, 1, 4, 1'b0);
      for (int i = 0; i < NCH; i++) begin
         if (i % 2 == 1) set_req(i, 1'b1, 1, i * 2, 1'b0);
         else            set_req(i, 1'b1, 0, i, 1'b0);
      end
      for (int k = 0; k < 10; k++) step(1'b0);
      bus.req_valid = '0;
      step(1'b0);
      step(1'b0);

      // 4: pointer at 8 after ch7; ch2 and ch8 contend, ch8 wins first
      single(7, 8, 7, 1'b0);
      set_req(2, 1'b1, 0, 14, 1'b0);
      set_req(8, 1'b1, 11, 7, 1'b0);
      step(1'b1);
      step(1'b1);
      step(1'b0);
      step(1'b0);

      // 5: out-of-range code, blank inverted, minus rows
      single(4, 13, 5, 1'b0);
      single(4, 10, 4, 1'b1);
      single(6, 11, 0, 1'b0);
      single(6, 11, 8, 1'b0);
      single(6, 11, 13, 1'b1);

      // same channel granted on consecutive cycles
      set_req(5, 1'b1, 0, 3, 1'b0);
      step(1'b0);
      set_req(5, 1'b1, 0, 14, 1'b1);
      step(1'b1);
      step(1'b0);
      step(1'b0);

      // 6a: flush the cycle after an accept
      set_req(1, 1'b1, 0, 0, 1'b0);
      step(1'b1);
      flush = 1'b1;
      set_req(2, 1'b1, 0, 3, 1'b0);
      step(1'b0);
      flush = 1'b0;
      bus.req_valid[2] = 1'b0;
      step(1'b0);
      step(1'b0);

      // 6b: reset pulse with a request in flight; pointer returns to 0
      set_req(1, 1'b1, 1, 5, 1'b0);
      step(1'b1);
      rst_n = 1'b0;
      #1;
      check("midreset_rsp_valid", {135'd0, bus.rsp_valid}, 144'd0);
      check("midreset_rsp_data", bus.rsp_data, 144'd0);
      q.delete();
      ptr_m = 0;
      for (int i = 0; i < NCH; i++) exp_data[i] = 16'h0000;
      #1;
      rst_n = 1'b1;
      step(1'b0);
      step(1'b0);
      set_req(3, 1'b1, 8, 7, 1'b0);
      set_req(0, 1'b1, 0, 15, 1'b0);
      step(1'b1);
      step(1'b1);
      step(1'b0);
      step(1'b0);

      check("queue_drained", 144'(q.size()), 144'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
